// File: rtl/crc4_ctrl.sv
// crc4_ctrl: word-serial CRC engine. A frame is opened with a generator
// polynomial and seed, then fed WCODE-bit words that are shifted in MSB
// first, one bit per clock, until the word flagged last has been consumed.
module crc4_ctrl #(
  parameter int WCODE = 5,
  parameter int WPOLY = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WPOLY-1:0] i_poly,
  input  logic [WPOLY-2:0] i_init,
  input  logic             i_valid,
  input  logic [WCODE-1:0] i_data,
  input  logic             i_last,
  output logic             o_ready,
  input  logic             i_ack,
  input  logic             i_abort,
  output logic [WPOLY-2:0] o_crc,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_err
);

  localparam int CW = (WCODE > 1) ? $clog2(WCODE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WPOLY-2:0] crc_q,   crc_d;
  logic [WPOLY-1:0] poly_q,  poly_d;
  logic [WCODE-1:0] data_q,  data_d;
  logic             last_q,  last_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             err_q,   err_d;
  logic             fb;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      crc_q   <= '0;
      poly_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      poly_q  <= poly_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; abort beats a same-cycle transfer or acknowledge and
  // leaves the CRC register untouched.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    poly_d  = poly_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    fb      = crc_q[WPOLY-2] ^ data_q[cnt_q];
    case (state_q)
      IDLE: begin
        if (i_start) begin
          // A polynomial without its top term is not a valid generator.
          if (i_poly[WPOLY-1]) begin
            poly_d  = i_poly;
            crc_d   = i_init;
            state_d = WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (i_valid) begin
          data_d  = i_data;
          last_d  = i_last;
          cnt_d   = CW'(WCODE - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          crc_d = {crc_q[WPOLY-3:0], 1'b0} ^ (fb ? poly_q[WPOLY-2:0] : '0);
          if (cnt_q == '0) state_d = last_q ? DONE : WAIT;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (i_abort || i_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready = (state_q == WAIT);
  assign o_done  = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_err   = err_q;
  assign o_crc   = crc_q;

endmodule

// File: doc/crc4_ctrl.md
CRC4_CTRL -- requirements
Module: crc4_ctrl

Interface
REQ-001 Parameter WCODE, default 5, SHALL be the data word width in bits (WCODE >= 2).
REQ-002 Parameter WPOLY, default 4, SHALL be the generator polynomial width including its x^(WPOLY-1) term (WPOLY >= 3).
REQ-003 i_clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 i_start  input  1  SHALL request a new CRC frame; sampled only in IDLE.
REQ-006 i_poly  input  WPOLY  SHALL be the generator polynomial, MSB = x^(WPOLY-1); latched on accepted start.
REQ-007 i_init  input  WPOLY-1  SHALL be the initial CRC register value; latched on accepted start.
REQ-008 i_valid  input  1  SHALL qualify i_data/i_last; a word transfers when i_valid and o_ready are both 1.
REQ-009 i_data  input  WCODE  SHALL be the data word, processed MSB first.
REQ-010 i_last  input  1  SHALL mark the final word of the frame.
REQ-011 o_ready  output  1  SHALL be 1 only in state WAIT.
REQ-012 i_ack  input  1  SHALL acknowledge the result in DONE.
REQ-013 i_abort  input  1  SHALL cancel the frame in progress.
REQ-014 o_crc  output  WPOLY-1  SHALL present the CRC register contents at all times.
REQ-015 o_done  output  1  SHALL be 1 only in state DONE.
REQ-016 o_busy  output  1  SHALL be 1 in WAIT, SHIFT and DONE.
REQ-017 o_err  output  1  SHALL be a one-cycle pulse flagging a rejected start.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, WAIT, SHIFT and DONE.
REQ-019 IDLE: i_start=1 with i_poly[WPOLY-1]=1 SHALL latch i_poly and i_init, load the CRC register with i_init, and go to WAIT next cycle.
REQ-020 IDLE: i_start=1 with i_poly[WPOLY-1]=0 SHALL assert o_err for the next cycle only and remain in IDLE, with the CRC register unchanged.
REQ-021 i_start outside IDLE SHALL be ignored (no latch, no o_err).
REQ-022 WAIT: a transfer SHALL latch i_data and i_last, set the bit counter to WCODE-1, and go to SHIFT.
REQ-023 SHIFT SHALL process one data bit per cycle, bit index = counter, with counter decrementing from WCODE-1 to 0.
REQ-024 Per bit d: fb = crc[WPOLY-2] ^ d; crc <= {crc[WPOLY-3:0],1'b0} ^ (fb ? poly[WPOLY-2:0] : 0).
REQ-025 On the cycle the counter is 0, the FSM SHALL go to DONE if the latched last flag is 1, else to WAIT.
REQ-026 Latency: word accepted at edge N; bits processed at edges N+1..N+WCODE; o_ready or o_done visible after edge N+WCODE.
REQ-027 Throughput SHALL be one word per WCODE+1 cycles; o_ready SHALL be 0 throughout SHIFT.
REQ-028 DONE SHALL hold o_crc stable until i_ack=1, then go to IDLE next cycle; o_crc SHALL retain its value in IDLE.
REQ-029 i_abort=1 in WAIT, SHIFT or DONE SHALL force IDLE next cycle without asserting o_done; o_crc keeps its current value.
REQ-030 i_abort SHALL take priority over a simultaneous transfer in WAIT and over i_ack in DONE.
REQ-031 i_valid while o_ready=0 SHALL have no effect; the source must hold the word.
REQ-032 A frame of k words SHALL equal (message·x^(WPOLY-1)) mod poly when i_init = 0, for a message of k·WCODE bits.

Reset
REQ-033 i_rst=1 at a rising edge SHALL force IDLE with o_crc=0, o_done=0, o_busy=0, o_err=0, counter=0, latched poly=0, latched last=0.
REQ-034 i_rst SHALL override every other input in any state, including mid-SHIFT; no result or o_err SHALL follow from the interrupted frame.

Verification (WCODE=5, WPOLY=4)
REQ-035 The bench SHALL check: start with poly=4'b1011, init=3'b000; one word 5'b00001 with last=1 -> o_done after 6 cycles, o_crc=3'b011.
REQ-036 The bench SHALL check: same setup; words 5'b00001 (last=0) then 5'b00000 (last=1) -> o_crc=3'b010 in DONE; o_ready high between the two words.
REQ-037 The bench SHALL check: single word 5'b10110 with last=1, poly=4'b1011 -> o_crc=3'b000; o_crc held for 3 cycles with i_ack=0, then IDLE one cycle after i_ack.
REQ-038 The bench SHALL check: start with poly=4'b0011 -> o_err=1 for exactly one cycle, o_busy=0, state stays IDLE.
REQ-039 The bench SHALL check: i_rst asserted on the 3rd SHIFT cycle -> next cycle all outputs 0, state IDLE, and no o_done afterwards.
REQ-040 The bench SHALL check: i_abort coinciding with a WAIT transfer -> IDLE, word not consumed, o_done never asserted.
